// File: rtl/tm1638_digit_fmt_if.sv
// rtl/tm1638_digit_fmt_if.sv - value/load request and segment-code result bus for the digit formatter
interface tm1638_digit_fmt_if;
  logic [9:0] value;
  logic       load;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [7:0] data3;
  logic       synch2;
  logic       busy;

  modport master (
    output value, load,
    input  data1, data2, data3, synch2, busy
  );

  modport slave (
    input  value, load,
    output data1, data2, data3, synch2, busy
  );
endinterface

// File: rtl/tm1638_digit_fmt.sv
// rtl/tm1638_digit_fmt.sv - converts a 10-bit value to three TM1638 seven-segment codes via double-dabble
module tm1638_digit_fmt #(
  parameter int BLANK_LZ = 1
) (
  input logic               clk,
  input logic               rst,
  tm1638_digit_fmt_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, ENC, SETTLE} state_t;

  state_t      state;
  state_t      state_nxt;

  logic [9:0]  bin_q;
  logic [11:0] bcd_q;
  logic [3:0]  step_q;
  logic        ovf_q;
  logic        pend_q;
  logic [9:0]  pend_val_q;
  logic [7:0]  data1_q;
  logic [7:0]  data2_q;
  logic [7:0]  data3_q;
  logic        synch2_q;

  logic        start;
  logic [9:0]  start_val;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_nxt;
  logic [9:0]  bin_nxt;
  logic [7:0]  enc1;
  logic [7:0]  enc2;
  logic [7:0]  enc3;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] d);
    add3 = (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // A live load always beats a queued one; the queued value is only used when load is idle.
  assign start     = (state == IDLE) && (bus.load || pend_q);
  assign start_val = bus.load ? bus.value : pend_val_q;

  always_comb begin
    bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bcd_nxt = {bcd_adj[10:0], bin_q[9]};
    bin_nxt = {bin_q[8:0], 1'b0};
  end

  always_comb begin
    enc1 = 8'h00;
    enc2 = 8'h00;
    enc3 = 8'h00;
    if (ovf_q) begin
      enc1 = 8'h40;
      enc2 = 8'h40;
      enc3 = 8'h40;
    end else begin
      enc1 = seg7(bcd_q[11:8]);
      enc2 = seg7(bcd_q[7:4]);
      enc3 = seg7(bcd_q[3:0]);
      if ((BLANK_LZ != 0) && (bcd_q[11:8] == 4'd0)) begin
        enc1 = 8'h00;
        if (bcd_q[7:4] == 4'd0) begin
          enc2 = 8'h00;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (step_q == 4'd9) state_nxt = ENC;
      ENC:     state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      data3_q    <= '0;
      synch2_q   <= 1'b0;
    end else begin
      // Loads arriving mid-conversion (including the SETTLE edge) queue here, newest wins.
      if (bus.load && (state != IDLE)) begin
        pend_val_q <= bus.value;
        pend_q     <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            bin_q    <= start_val;
            bcd_q    <= '0;
            step_q   <= '0;
            ovf_q    <= (start_val > 10'd999);
            synch2_q <= 1'b0;
            pend_q   <= 1'b0;
          end
        end
        CONV: begin
          bin_q  <= bin_nxt;
          bcd_q  <= bcd_nxt;
          step_q <= step_q + 4'd1;
        end
        ENC: begin
          data1_q <= enc1;
          data2_q <= enc2;
          data3_q <= enc3;
        end
        SETTLE: begin
          synch2_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.data1  = data1_q;
  assign bus.data2  = data2_q;
  assign bus.data3  = data3_q;
  assign bus.synch2 = synch2_q;
  assign bus.busy   = (state != IDLE) || pend_q;

endmodule

// File: tb/tb_tm1638_digit_fmt.sv
// tb/tb_tm1638_digit_fmt.sv - directed vector bench for tm1638_digit_fmt
module tb_tm1638_digit_fmt;

  logic clk;
  logic rst;

  tm1638_digit_fmt_if bus();
  tm1638_digit_fmt_if bus0();

  tm1638_digit_fmt #(.BLANK_LZ(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  tm1638_digit_fmt #(.BLANK_LZ(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] v;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
  } vec_t;

  vec_t vecs[11];

  int errors = 0;
  int checks = 0;

  logic [23:0] prev_disp;
  logic        s2_hi_early;
  logic        busy_dropped;
  logic        seen_999;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_watch;
    tick();
    if (!bus.busy) busy_dropped = 1'b1;
    if (bus.data1 == 8'h6F && bus.data2 == 8'h6F && bus.data3 == 8'h6F) seen_999 = 1'b1;
  endtask

  task automatic pulse_load(input logic [9:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  function automatic logic [23:0] disp();
    return {bus.data1, bus.data2, bus.data3};
  endfunction

  initial begin
    rst        = 1'b0;
    bus.value  = '0;
    bus.load   = 1'b0;
    bus0.value = '0;
    bus0.load  = 1'b0;

    vecs[0]  = '{10'd0,    8'h00, 8'h00, 8'h3F};
    vecs[1]  = '{10'd507,  8'h6D, 8'h3F, 8'h07};
    vecs[2]  = '{10'd1000, 8'h40, 8'h40, 8'h40};
    vecs[3]  = '{10'd1023, 8'h40, 8'h40, 8'h40};
    vecs[4]  = '{10'd5,    8'h00, 8'h00, 8'h6D};
    vecs[5]  = '{10'd999,  8'h6F, 8'h6F, 8'h6F};
    vecs[6]  = '{10'd100,  8'h06, 8'h3F, 8'h3F};
    vecs[7]  = '{10'd10,   8'h00, 8'h06, 8'h3F};
    vecs[8]  = '{10'd42,   8'h00, 8'h66, 8'h5B};
    vecs[9]  = '{10'd7,    8'h00, 8'h00, 8'h07};
    vecs[10] = '{10'd250,  8'h5B, 8'h6D, 8'h3F};

    #2;
    chk("reset_data", disp(), 24'h000000);
    chk("reset_synch2", bus.synch2, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("post_reset_synch2", bus.synch2, 1'b0);
    chk("post_reset_busy", bus.busy, 1'b0);

    prev_disp = 24'h000000;
    for (int i = 0; i < 11; i++) begin
      s2_hi_early = 1'b0;
      pulse_load(vecs[i].v);
      chk($sformatf("v%0d_busy_e0", vecs[i].v), bus.busy, 1'b1);
      if (bus.synch2) s2_hi_early = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (bus.synch2) s2_hi_early = 1'b1;
      end
      chk($sformatf("v%0d_hold_e10", vecs[i].v), disp(), prev_disp);
      tick();
      if (bus.synch2) s2_hi_early = 1'b1;
      chk($sformatf("v%0d_synch2_low_e0_e11", vecs[i].v), s2_hi_early, 1'b0);
      chk($sformatf("v%0d_data_e11", vecs[i].v), disp(), {vecs[i].d1, vecs[i].d2, vecs[i].d3});
      tick();
      chk($sformatf("v%0d_synch2_e12", vecs[i].v), bus.synch2, 1'b1);
      chk($sformatf("v%0d_busy_e12", vecs[i].v), bus.busy, 1'b0);
      prev_disp = {vecs[i].d1, vecs[i].d2, vecs[i].d3};
      tick();
    end

    // 42 at E0, 999 at E5, 7 at E8: 999 is overwritten in the pending slot.
    busy_dropped = 1'b0;
    seen_999     = 1'b0;
    pulse_load(10'd42);
    for (int k = 1; k <= 4; k++) tick_watch();
    bus.value = 10'd999;
    bus.load  = 1'b1;
    tick_watch();
    bus.load  = 1'b0;
    for (int k = 6; k <= 7; k++) tick_watch();
    bus.value = 10'd7;
    bus.load  = 1'b1;
    tick_watch();
    bus.load  = 1'b0;
    for (int k = 9; k <= 12; k++) tick_watch();
    chk("pend_first_data", disp(), 24'h00665B);
    chk("pend_first_synch2", bus.synch2, 1'b1);
    chk("pend_first_busy", bus.busy, 1'b1);
    tick_watch();
    chk("pend_start_synch2", bus.synch2, 1'b0);
    for (int k = 1; k <= 11; k++) tick_watch();
    tick();
    chk("pend_second_data", disp(), 24'h000007);
    chk("pend_second_synch2", bus.synch2, 1'b1);
    chk("pend_second_busy", bus.busy, 1'b0);
    chk("pend_busy_held", busy_dropped, 1'b0);
    chk("pend_999_never_shown", seen_999, 1'b0);
    tick();

    // Load landing on the SETTLE edge must be queued.
    pulse_load(10'd10);
    for (int k = 1; k <= 11; k++) tick();
    bus.value = 10'd250;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
    chk("settle_load_data", disp(), 24'h00063F);
    chk("settle_load_busy", bus.busy, 1'b1);
    for (int k = 13; k <= 25; k++) tick();
    chk("settle_load_result", disp(), 24'h5B6D3F);
    chk("settle_load_synch2", bus.synch2, 1'b1);
    tick();

    // Live load in IDLE wins over a pending value and clears it.
    pulse_load(10'd10);
    for (int k = 1; k <= 11; k++) tick();
    bus.value = 10'd250;
    bus.load  = 1'b1;
    tick();
    bus.value = 10'd100;
    tick();
    bus.load  = 1'b0;
    for (int k = 14; k <= 25; k++) tick();
    chk("live_prio_data", disp(), 24'h063F3F);
    chk("live_prio_busy", bus.busy, 1'b0);
    for (int k = 0; k < 15; k++) tick();
    chk("live_prio_no_rerun", disp(), 24'h063F3F);

    // Reset asserted mid-conversion.
    pulse_load(10'd507);
    for (int k = 1; k <= 5; k++) tick();
    rst = 1'b0;
    #1;
    chk("midrst_data", disp(), 24'h000000);
    chk("midrst_synch2", bus.synch2, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("midrst_after_data", disp(), 24'h000000);
    chk("midrst_after_synch2", bus.synch2, 1'b0);
    chk("midrst_after_busy", bus.busy, 1'b0);

    // Leading zeros shown when BLANK_LZ=0; overflow still dashes.
    bus0.value = 10'd5;
    bus0.load  = 1'b1;
    tick();
    bus0.load  = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    chk("nolz_5", {bus0.data1, bus0.data2, bus0.data3}, 24'h3F3F6D);
    chk("nolz_5_synch2", bus0.synch2, 1'b1);
    tick();
    bus0.value = 10'd1023;
    bus0.load  = 1'b1;
    tick();
    bus0.load  = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    chk("nolz_1023", {bus0.data1, bus0.data2, bus0.data3}, 24'h404040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
